// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting N_REQ DMA requesters access to one memory read port.
// Each grant is held while the owner requests, up to MAX_HOLD cycles, then released for two cycles.
module bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 10,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  output logic [N_REQ-1:0]          grant,
  output logic [DATA_W-1:0]         indata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [N_REQ-1:0]    r_grant, w_grant_nxt;
  logic [OW-1:0]       r_owner, w_owner_nxt;
  logic [OW-1:0]       r_rr_ptr, w_rr_nxt;
  logic [HW-1:0]       r_hold, w_hold_nxt;
  logic                r_mem_rd, w_rd_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_maddr_nxt;
  logic                r_busy;
  logic [DATA_W-1:0]   r_indata;

  logic [ADDR_W-1:0]   w_addr_arr [N_REQ];
  logic                w_found;
  logic [OW-1:0]       w_winner;
  logic [OW:0]         w_sum;
  logic [OW-1:0]       w_idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign w_addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
  end

  // First requester at or above rr_ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (OW+1)'(k);
      if (w_sum >= (OW+1)'(N_REQ)) w_sum = w_sum - (OW+1)'(N_REQ);
      w_idx = w_sum[OW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = '0;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_hold_nxt  = r_hold;
    w_rd_nxt    = 1'b0;
    w_maddr_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OWN;
          w_grant_nxt = N_REQ'(1) << w_winner;
          w_owner_nxt = w_winner;
          w_hold_nxt  = HW'(1);
          w_rd_nxt    = 1'b1;
          w_maddr_nxt = w_addr_arr[w_winner];
        end
      end
      S_OWN: begin
        if (!req[r_owner] || r_hold == HW'(MAX_HOLD)) begin
          w_state_nxt = S_RELEASE;
        end else begin
          w_grant_nxt = r_grant;
          w_rd_nxt    = 1'b1;
          w_maddr_nxt = w_addr_arr[r_owner];
          if (r_hold != HW'(MAX_HOLD)) w_hold_nxt = r_hold + HW'(1);
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = '0;
        w_rr_nxt    = (r_owner == OW'(N_REQ-1)) ? '0 : r_owner + OW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold     <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_indata   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_hold     <= w_hold_nxt;
      r_mem_rd   <= w_rd_nxt;
      r_mem_addr <= w_maddr_nxt;
      r_busy     <= |w_grant_nxt;
      r_indata   <= r_mem_rd ? mem_rdata : '0;
    end
  end

  assign grant     = r_grant;
  assign indata    = r_indata;
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: cycle scoreboard against a reference model, an arbitration
// vector table, and directed sequences for hold limit, round-robin and mid-transfer reset.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 10;
  localparam int EW = 2 + N + 2 + 1 + 1 + AW + DW;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [AW-1:0] a_arr [N];
  logic [N*AW-1:0] addr;
  logic [N-1:0]  grant;
  logic [DW-1:0] indata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;
  logic          busy;
  logic [1:0]    dbg_state;

  assign addr = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};

  bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .grant(grant), .indata(indata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .owner(owner),
    .busy(busy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int            m_st, m_ptr, m_owner, m_hold;
  logic [N-1:0]  m_grant;
  logic          m_rd;
  logic [AW-1:0] m_maddr;
  logic [DW-1:0] m_indata;

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_owner = 0; m_hold = 0;
    m_grant = '0; m_rd = 1'b0; m_maddr = '0; m_indata = '0;
  endtask

  task automatic model_step();
    int w, j;
    logic [DW-1:0] nd;
    nd = m_rd ? mem_rdata : '0;
    case (m_st)
      0: begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && req[j[1:0]]) w = j;
        end
        if (w >= 0) begin
          m_st = 1; m_grant = '0; m_grant[w[1:0]] = 1'b1; m_owner = w; m_hold = 1;
          m_rd = 1'b1; m_maddr = a_arr[w[1:0]];
        end else begin
          m_grant = '0; m_rd = 1'b0; m_maddr = '0;
        end
      end
      1: begin
        if (!req[m_owner[1:0]] || m_hold >= 8) begin
          m_st = 2; m_grant = '0; m_rd = 1'b0; m_maddr = '0;
        end else begin
          m_hold++; m_maddr = a_arr[m_owner[1:0]];
        end
      end
      default: begin
        m_ptr = (m_owner + 1) % N; m_st = 0;
      end
    endcase
    m_indata = nd;
  endtask

  function automatic logic [EW-1:0] dut_pack();
    return {dbg_state, grant, owner, busy, mem_rd, mem_addr, indata};
  endfunction

  // One clock: model predicts, DUT is sampled on the falling edge and compared.
  task automatic tick(input int rd = -1);
    logic [EW-1:0] e;
    mem_rdata = (rd < 0) ? DW'($urandom_range(1, 1023)) : DW'(rd);
    model_step();
    exp_q.push_back({m_st[1:0], m_grant, m_owner[1:0], |m_grant, m_rd, m_maddr, m_indata});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("scoreboard", 64'(dut_pack()), 64'(e));
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1 chk("reset_outputs", 64'(dut_pack()), 64'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Protocol properties checked every cycle
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      chk("mem_rd_eq_grant", 64'(mem_rd), 64'(|grant));
      chk("busy_eq_grant", 64'(busy), 64'(|grant));
      chk("indata_after_rd", 64'((indata == '0) || prev_rd), 64'd1);
      prev_rd = mem_rd;
    end else begin
      prev_rd = 1'b0;
    end
  end

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_grant;
  } vec_t;

  vec_t tbl [10];
  logic [N-1:0] eg;

  initial begin
    // rr_ptr walk: 0 ->1 ->2 ->1 ->2 ->3 ->1 ->2 ->0 ->0 ->1
    tbl[0] = '{4'b0001, 4'b0001};
    tbl[1] = '{4'b0011, 4'b0010};
    tbl[2] = '{4'b0011, 4'b0001};
    tbl[3] = '{4'b1110, 4'b0010};
    tbl[4] = '{4'b1100, 4'b0100};
    tbl[5] = '{4'b0101, 4'b0001};
    tbl[6] = '{4'b1010, 4'b0010};
    tbl[7] = '{4'b1001, 4'b1000};
    tbl[8] = '{4'b0000, 4'b0000};
    tbl[9] = '{4'b1111, 4'b0001};

    rst = 1'b0; req = '0; mem_rdata = '0;
    for (int i = 0; i < N; i++) a_arr[i] = AW'($urandom);
    model_reset();
    #2 chk("power_on_reset", 64'(dut_pack()), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Arbitration table: grant, drop, release, back to idle
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(tbl[i].exp_grant));
      req = '0;
      tick();
      tick();
    end

    // Single requester with fixed address and read data
    do_reset();
    a_arr[0] = 14'h0123;
    req = 4'b0001;
    tick(7);
    chk("single_grant", 64'(grant), 64'h1);
    chk("single_mem_addr", 64'(mem_addr), 64'h0123);
    chk("single_mem_rd", 64'(mem_rd), 64'h1);
    tick(7);
    chk("single_indata", 64'(indata), 64'd7);
    req = '0;
    tick(7);
    chk("single_drop_grant", 64'(grant), 64'h0);
    chk("single_drop_busy", 64'(busy), 64'h0);

    // Round-robin with all requesting: 8 owned cycles, 2 gap cycles, rotating
    do_reset();
    req = 4'b1111;
    for (int t = 1; t <= 50; t++) begin
      tick();
      eg = ((t - 1) % 10 < 8) ? (N'(1) << (((t - 1) / 10) % 4)) : '0;
      chk($sformatf("rr_t%0d", t), 64'(grant), 64'(eg));
    end
    req = '0;
    tick();

    // Hold limit: lone requester is cut at 8 cycles and re-granted after the gap
    do_reset();
    req = 4'b0001;
    for (int t = 1; t <= 20; t++) begin
      tick();
      eg = (t <= 8 || (t >= 11 && t <= 18)) ? 4'b0001 : 4'b0000;
      chk($sformatf("hold_t%0d", t), 64'(grant), 64'(eg));
    end
    req = '0;
    tick();

    // Reset during the third owned cycle of requester 2
    do_reset();
    req = 4'b0100;
    tick(); tick(); tick();
    chk("midrst_pre_grant", 64'(grant), 64'h4);
    #2 rst = 1'b0;
    #1;
    chk("midrst_grant", 64'(grant), 64'h0);
    chk("midrst_indata", 64'(indata), 64'h0);
    chk("midrst_state", 64'(dbg_state), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midrst_regrant", 64'(grant), 64'h4);
    req = '0;
    tick(); tick();

    // A request withdrawn before being granted is never granted
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0011; tick(); tick();
    req = 4'b0001; tick();
    req = 4'b0000; tick(); tick();
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("withdrawn_not_granted", 64'(grant), 64'h0);
    end

    // Random traffic against the model
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      if ((t % 16) == 0) for (int i = 0; i < N; i++) a_arr[i] = AW'($urandom);
      tick();
    end
    req = '0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
